frame_streamer: RTL and testbench
=================================

FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 32, FIFO word width; DEPTH, 32, frame table entries (power of 2); GAP_W, 24, inter-frame gap counter width; REP_W, 16, repeat counter width.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk_50_mhz, in, 1, sole clock.
- rst, in, 1, sync active-high reset.
- tbl_we, in, 1, frame table write strobe.
- tbl_addr, in, log2(DEPTH), table write address.
- tbl_din, in, DATA_W, table write data.
- cfg_len, in, log2(DEPTH)+1, words per frame (1..DEPTH).
- cfg_gap, in, GAP_W, idle cycles before each frame.
- cfg_repeat, in, REP_W, frames per run; 0 = continuous.
- start, in, 1, begin run (level sampled).
- abort, in, 1, stop run immediately.
- fifo_full, in, 1, downstream tx FIFO full.
- fifo_din, out, DATA_W, word to FIFO.
- fifo_wr_en, out, 1, FIFO write strobe.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle pulse at run end.
- frames_sent, out, 32, completed frames since reset, wraps.

Function
REQ-004 FSM states: IDLE, GAP, FETCH, SEND.
REQ-005 IDLE: start=1 with cfg_len in 1..DEPTH latches cfg_len/cfg_gap/cfg_repeat, sets busy next cycle, enters GAP (cfg_gap>0) or FETCH (cfg_gap=0).
REQ-006 start with cfg_len=0 or cfg_len>DEPTH: no FIFO writes, done pulses next cycle, stays IDLE.
REQ-007 start while busy SHALL be ignored; configuration inputs ignored while busy.
REQ-008 GAP: counts exactly cfg_gap cycles, then FETCH.
REQ-009 FETCH: one cycle presenting table address 0; table read latency exactly 1 cycle; then SEND.
REQ-010 SEND: fifo_wr_en = word_valid AND NOT fifo_full (combinational on fifo_full); fifo_din holds the current word stable until accepted.
REQ-011 Accepted word (fifo_wr_en=1) advances address; next word valid next cycle, so writes are back-to-back while fifo_full=0.
REQ-012 fifo_full=1 SHALL stall with no word lost, duplicated or reordered; fifo_wr_en SHALL never be 1 while fifo_full=1.
REQ-013 With start at edge T and cfg_gap=G, first fifo_wr_en SHALL occur in cycle T+G+2 (fifo not full).
REQ-014 Last word (index cfg_len-1) accepted: frames_sent increments; if more frames remain, next cycle enters GAP/FETCH, giving exactly G+1 cycles with fifo_wr_en=0 between frames; otherwise IDLE, busy=0, done=1 for one cycle.
REQ-015 cfg_repeat=0: frames repeat until abort.
REQ-016 abort (any non-IDLE state): fifo_wr_en=0 in the same cycle, IDLE next cycle, done pulses, frames_sent not incremented for the partial frame; abort has priority over start.
REQ-017 Table writes accepted only in IDLE; tbl_we while busy ignored. Table contents persist through rst (not cleared).
REQ-018 Counters compare full-width; address wraps never occur because cfg_len<=DEPTH.

Reset
REQ-019 rst: state IDLE, fifo_wr_en=0, fifo_din=0, busy=0, done=0, frames_sent=0, internal counters 0; rst mid-frame drops the frame with no further writes.

Structure
REQ-020 Shared package: state encoding, default parameter values, clog2 helper.
REQ-021 One sub-module: frame_table (DEPTH x DATA_W, 1 write port, registered 1-cycle read port).

Verification
REQ-022 Load 15-word frame (55555555, 555555D5, FFFFFFFF, ...), cfg_len=15, gap=0, repeat=1, start -> 15 consecutive writes starting T+2, table order, done once, frames_sent=1.
REQ-023 Same frame, fifo_full toggled randomly 50% -> identical 15-word sequence, no write while full.
REQ-024 cfg_len=4, gap=10, repeat=3 -> first write T+12, 11 idle cycles between frames, 12 writes total, frames_sent=3.
REQ-025 repeat=0, abort after 2.5 frames -> writes stop same cycle, frames_sent=2, done pulse, busy=0.
REQ-026 cfg_len=0 start -> no writes, done at T+1; second start during run and tbl_we during run -> no effect.
REQ-027 rst asserted mid-frame -> all outputs reset values next cycle; new run afterwards uses unchanged table.

Source files
------------

// File: rtl/frame_streamer_pkg.sv
// frame_streamer_pkg: FSM state encoding, default parameters and width helper
package frame_streamer_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_GAP_W  = 24;
    localparam int DEF_REP_W  = 16;

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_FETCH, S_SEND} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/frame_streamer_if.sv
// frame_streamer_if: table load, run control and FIFO write signals of the frame streamer
interface frame_streamer_if
    import frame_streamer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int REP_W  = DEF_REP_W
);
    localparam int AW = clog2(DEPTH);

    logic              tbl_we;
    logic [AW-1:0]     tbl_addr;
    logic [DATA_W-1:0] tbl_din;
    logic [AW:0]       cfg_len;
    logic [GAP_W-1:0]  cfg_gap;
    logic [REP_W-1:0]  cfg_repeat;
    logic              start;
    logic              abort;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_din;
    logic              fifo_wr_en;
    logic              busy;
    logic              done;
    logic [31:0]       frames_sent;

    modport master (
        output tbl_we, tbl_addr, tbl_din, cfg_len, cfg_gap, cfg_repeat, start, abort, fifo_full,
        input  fifo_din, fifo_wr_en, busy, done, frames_sent
    );
    modport slave (
        input  tbl_we, tbl_addr, tbl_din, cfg_len, cfg_gap, cfg_repeat, start, abort, fifo_full,
        output fifo_din, fifo_wr_en, busy, done, frames_sent
    );
endinterface

// File: rtl/frame_streamer_frame_table.sv
// frame_table: DEPTH x DATA_W frame memory, one write port, registered read port; contents survive reset
module frame_table #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: replays a stored frame into a tx FIFO with inter-frame gaps and repeat count
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int REP_W  = DEF_REP_W
) (
    input logic             clk_50_mhz,
    input logic             rst,
    frame_streamer_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_next_frame;
    logic [LW-1:0]     r_len;
    logic [LW-1:0]     r_addr;
    logic [LW-1:0]     w_addr_inc;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  r_gcnt;
    logic [REP_W-1:0]  r_rep;
    logic [REP_W-1:0]  r_fcnt;
    logic [31:0]       r_frames;
    logic              r_done;
    logic [DATA_W-1:0] w_rdata;
    logic [AW-1:0]     w_rd_addr;
    logic              w_tbl_we;
    logic              w_cfg_ok;
    logic              w_go;
    logic              w_wr;
    logic              w_last;
    logic              w_run_end;

    frame_table #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_table (
        .clk    (clk_50_mhz),
        .i_we   (w_tbl_we),
        .i_waddr(bus.tbl_addr),
        .i_wdata(bus.tbl_din),
        .i_raddr(w_rd_addr),
        .o_rdata(w_rdata)
    );

    // The read address runs one word ahead on accept so the next word is ready the following cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_tbl_we     = bus.tbl_we && r_state == S_IDLE;
        w_cfg_ok     = bus.cfg_len != '0 && bus.cfg_len <= LW'(DEPTH);
        w_go         = r_state == S_IDLE && bus.start && !bus.abort;
        w_wr         = r_state == S_SEND && !bus.fifo_full && !bus.abort && !rst;
        w_addr_inc   = r_addr + 1'b1;
        w_last       = w_wr && w_addr_inc == r_len;
        w_run_end    = w_last && r_rep != '0 && r_fcnt + 1'b1 == r_rep;
        w_next_frame = r_gap != '0 ? S_GAP : S_FETCH;
        w_rd_addr    = r_state == S_SEND ? (w_wr ? w_addr_inc[AW-1:0] : r_addr[AW-1:0]) : '0;
        if (r_state != S_IDLE && bus.abort) w_state_nxt = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:  if (w_go && w_cfg_ok) w_state_nxt = bus.cfg_gap != '0 ? S_GAP : S_FETCH;
                S_GAP:   if (r_gcnt == r_gap - 1'b1) w_state_nxt = S_FETCH;
                S_FETCH: w_state_nxt = S_SEND;
                S_SEND:  if (w_last) w_state_nxt = w_run_end ? S_IDLE : w_next_frame;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50_mhz) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_addr   <= '0;
            r_gap    <= '0;
            r_gcnt   <= '0;
            r_rep    <= '0;
            r_fcnt   <= '0;
            r_frames <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_go && !w_cfg_ok) || w_run_end || (r_state != S_IDLE && bus.abort);
            r_gcnt  <= (r_state == S_GAP && w_state_nxt == S_GAP) ? r_gcnt + 1'b1 : '0;
            r_addr  <= w_state_nxt == S_SEND ? (w_wr ? w_addr_inc : r_addr) : '0;
            if (w_go && w_cfg_ok) begin
                r_len  <= bus.cfg_len;
                r_gap  <= bus.cfg_gap;
                r_rep  <= bus.cfg_repeat;
                r_fcnt <= '0;
            end
            if (w_last) begin
                r_frames <= r_frames + 1'b1;
                r_fcnt   <= r_fcnt + 1'b1;
            end
        end
    end

    assign bus.fifo_wr_en  = w_wr;
    assign bus.fifo_din    = r_state == S_SEND ? w_rdata : '0;
    assign bus.busy        = r_state != S_IDLE;
    assign bus.done        = r_done;
    assign bus.frames_sent = r_frames;
endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: directed runs with a scoreboard of expected words and write cycles
module tb_frame_streamer;
    import frame_streamer_pkg::*;
    localparam int DW = 32;
    localparam int DP = 32;
    localparam int GW = 24;
    localparam int RW = 16;
    localparam int LW = clog2(DP) + 1;
    localparam int AW = clog2(DP);

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    logic        clk_50_mhz = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          t;
    int          d0;
    exp_t        exp_q[$];
    exp_t        e_m;
    logic [31:0] tbl [15] = '{32'h55555555, 32'h555555D5, 32'hFFFFFFFF, 32'hFFFF0011, 32'h22334455,
                              32'h08000045, 32'h00002E00, 32'h00004000, 32'h40110000, 32'hC0A80001,
                              32'hC0A80002, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0};

    frame_streamer_if #(.DATA_W(DW), .DEPTH(DP), .GAP_W(GW), .REP_W(RW)) bus ();

    frame_streamer #(.DATA_W(DW), .DEPTH(DP), .GAP_W(GW), .REP_W(RW)) dut (
        .clk_50_mhz(clk_50_mhz),
        .rst       (rst),
        .bus       (bus)
    );

    always #10 clk_50_mhz = ~clk_50_mhz;
    always @(posedge clk_50_mhz) cyc <= cyc + 1;

    // Monitor: every observed FIFO write is matched against the head of the scoreboard
    always @(negedge clk_50_mhz) begin
        if (bus.done) done_cnt++;
        if (bus.fifo_wr_en) begin
            checks++;
            if (bus.fifo_full) begin
                failures++;
                $display("FAIL wr_while_full: fifo_wr_en=1 with fifo_full=1 at cycle %0d", cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got %h at cycle %0d, expected no write", bus.fifo_din, cyc);
            end else begin
                e_m = exp_q.pop_front();
                if (bus.fifo_din !== e_m.d) begin
                    failures++;
                    $display("FAIL write_data: got %h expected %h", bus.fifo_din, e_m.d);
                end
                if (e_m.c >= 0) begin
                    checks++;
                    if (cyc != e_m.c) begin
                        failures++;
                        $display("FAIL write_cycle: got %0d expected %0d", cyc, e_m.c);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_50_mhz);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask

    task automatic push(input logic [31:0] d, input int c);
        exp_t e;
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
    endtask

    // Queue nw words of a run started at edge ts; timed entries carry their monitor cycle
    task automatic expect_words(input int ts, input int len, input int gap, input int nw, input bit timed);
        for (int i = 0; i < nw; i++)
            push(tbl[i % len], timed ? ts + gap + 1 + (i / len) * (len + gap + 1) + (i % len) : -1);
    endtask

    task automatic start_run(input int len, input int gap, input int rep);
        bus.cfg_len    = LW'(len);
        bus.cfg_gap    = GW'(gap);
        bus.cfg_repeat = RW'(rep);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd, input string n);
        int k;
        k = 0;
        while (bus.busy && k < 3000) begin
            if (rnd) bus.fifo_full = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        bus.fifo_full = 1'b0;
        tick();
        chk({n, "_timeout"}, 32'(k < 3000), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string n);
        chk({n, "_busy"}, 32'(bus.busy), 32'd0);
        chk({n, "_done"}, 32'(bus.done), 32'd0);
        chk({n, "_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
        chk({n, "_din"}, bus.fifo_din, 32'd0);
        chk({n, "_frames"}, bus.frames_sent, 32'd0);
    endtask

    initial begin
        bus.tbl_we = 0; bus.tbl_addr = '0; bus.tbl_din = '0;
        bus.cfg_len = '0; bus.cfg_gap = '0; bus.cfg_repeat = '0;
        bus.start = 0; bus.abort = 0; bus.fifo_full = 0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.tbl_we = 1'b1; bus.tbl_addr = AW'(i); bus.tbl_din = tbl[i];
            tick();
        end
        bus.tbl_we = 1'b0;

        // Single 15-word frame, no gap
        d0 = done_cnt; t = cyc + 1;
        expect_words(t, 15, 0, 15, 1);
        start_run(15, 0, 1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        wait_idle(0, "t1");
        chk("t1_left", exp_q.size(), 0);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_frames", bus.frames_sent, 1);

        // Same frame with random back-pressure
        d0 = done_cnt; t = cyc + 1;
        expect_words(t, 15, 0, 15, 0);
        start_run(15, 0, 1);
        wait_idle(1, "t2");
        chk("t2_left", exp_q.size(), 0);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_frames", bus.frames_sent, 2);

        // Three 4-word frames with a 10-cycle gap
        d0 = done_cnt; t = cyc + 1;
        expect_words(t, 4, 10, 12, 1);
        start_run(4, 10, 3);
        wait_idle(0, "t3");
        chk("t3_left", exp_q.size(), 0);
        chk("t3_done", done_cnt - d0, 1);
        chk("t3_frames", bus.frames_sent, 5);

        // Continuous run aborted in the middle of the third frame
        d0 = done_cnt; t = cyc + 1;
        expect_words(t, 4, 2, 10, 1);
        start_run(4, 2, 0);
        repeat (19) tick();
        bus.abort = 1'b1;
        #1;
        chk("t4_abort_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        tick();
        bus.abort = 1'b0;
        chk("t4_busy", 32'(bus.busy), 32'd0);
        chk("t4_done", 32'(bus.done), 32'd1);
        tick();
        chk("t4_left", exp_q.size(), 0);
        chk("t4_done_cnt", done_cnt - d0, 1);
        chk("t4_frames", bus.frames_sent, 7);

        // Illegal lengths: immediate done, no run
        d0 = done_cnt;
        start_run(0, 0, 1);
        chk("t5_len0_done", 32'(bus.done), 32'd1);
        chk("t5_len0_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("t5_len0_done_low", 32'(bus.done), 32'd0);
        start_run(DP + 1, 0, 1);
        chk("t5_len33_done", 32'(bus.done), 32'd1);
        chk("t5_len33_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("t5_bad_done_cnt", done_cnt - d0, 2);

        // Restart and table write during a run are ignored
        d0 = done_cnt; t = cyc + 1;
        expect_words(t, 4, 0, 8, 1);
        start_run(4, 0, 2);
        repeat (3) tick();
        bus.cfg_len = LW'(1); bus.cfg_gap = GW'(5); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.tbl_we = 1'b1; bus.tbl_addr = AW'(1); bus.tbl_din = 32'hBADBAD00;
        tick();
        bus.tbl_we = 1'b0;
        wait_idle(0, "t5");
        chk("t5_left", exp_q.size(), 0);
        chk("t5_done", done_cnt - d0, 1);
        chk("t5_frames", bus.frames_sent, 9);

        // Reset in mid-frame, then a fresh run from the untouched table
        t = cyc + 1;
        expect_words(t, 15, 0, 5, 1);
        start_run(15, 0, 1);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("t6_rst");
        rst = 1'b0;
        tick();
        chk("t6_left_after_rst", exp_q.size(), 0);
        d0 = done_cnt; t = cyc + 1;
        expect_words(t, 15, 0, 15, 1);
        start_run(15, 0, 1);
        wait_idle(0, "t6");
        chk("t6_left", exp_q.size(), 0);
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_frames", bus.frames_sent, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
